data_memory_port: RTL and testbench
===================================

DATA_MEMORY_PORT -- requirements
Module: data_memory_port

Interface
REQ-001 SHALL have parameter WORDS, default 256: memory depth in 32-bit words, power of two, 2..65536.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to response, 1..15.
REQ-003 SHALL have derived localparam ADDR_W = $clog2(4*WORDS): byte-address width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-010 req_signed  input  1  loads: 1 sign-extend, 0 zero-extend.
REQ-011 req_addr  input  ADDR_W  byte address.
REQ-012 req_wdata  input  32  store data, right-justified.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-016 rsp_err  output  1  request rejected (misaligned or size 11).

Function
REQ-017 Storage SHALL be a WORDS*4 byte array in big-endian order: address A holds bits 31:24 of the word at A&~3.
REQ-018 FSM SHALL have states IDLE, WAIT and RESP; req_ready=1 only in IDLE.
REQ-019 A request SHALL be accepted on the edge where req_valid and req_ready are both 1; all req_* fields are captured at that edge.
REQ-020 IDLE SHALL go to RESP on acceptance if LATENCY=1, otherwise to WAIT with a down-counter loaded with LATENCY-2.
REQ-021 WAIT SHALL decrement each cycle and go to RESP on the edge where the counter is 0.
REQ-022 rsp_valid SHALL assert exactly LATENCY cycles after acceptance and hold, with stable rsp_rdata and rsp_err, until rsp_ready=1.
REQ-023 RESP with rsp_ready=1 SHALL go to IDLE; the next request can be accepted no earlier than the following cycle. At most one request is outstanding.
REQ-024 Memory read and write SHALL occur on the edge entering RESP.
REQ-025 Store byte SHALL write req_wdata[7:0] to A; store half SHALL write [15:8] to A and [7:0] to A+1; store word SHALL write [31:24]..[7:0] to A..A+3.
REQ-026 Load byte and load half SHALL right-justify bytes in the same order and extend per req_signed; load word SHALL ignore req_signed.
REQ-027 Byte lanes outside a store's size SHALL be left unmodified.
REQ-028 Size 11 SHALL produce rsp_err=1, no memory write, and rsp_rdata=0, with normal LATENCY timing.
REQ-029 Inputs other than rsp_ready SHALL be ignored outside IDLE.

Reset
REQ-030 rst_n low SHALL immediately set state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-031 Memory contents SHALL NOT be reset; they are undefined after power-up.
REQ-032 Reset asserted before a store's commit edge SHALL drop the store; memory is unchanged.
REQ-033 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-034 With DMEM_MISALIGN_TRAP_EN defined, a half access with A[0]=1 or a word access with A[1:0]!=0 SHALL give rsp_err=1, no write and rsp_rdata=0.
REQ-035 Without DMEM_MISALIGN_TRAP_EN, misaligned addresses SHALL be aligned down (half: A[0]=0; word: A[1:0]=0), and the access SHALL complete with rsp_err=0.
REQ-036 In both builds, accesses SHALL never wrap past the last byte.

Verification (WORDS=256, LATENCY=2)
REQ-037 Store word 0x11223344 @0x10, then load word @0x10 -> rsp_rdata=0x11223344, rsp_valid exactly 2 cycles after each acceptance.
REQ-038 After REQ-037: store byte 0xAB @0x12, load word @0x10 -> 0x1122AB44; load byte signed @0x12 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-039 Load half @0x11: with DMEM_MISALIGN_TRAP_EN -> rsp_err=1, rdata=0; without -> rdata=0x00001122 (unsigned), err=0.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stable, req_ready=0; release -> IDLE next cycle.
REQ-041 Accept store word 0xDEADBEEF @0x20, pulse rst_n low in WAIT, then load @0x20 -> prior contents unchanged; all outputs at reset values during reset.
REQ-042 Request with req_size=11 -> rsp_err=1, rdata=0, memory unchanged, normal timing.

Source files
------------

// File: rtl/data_memory_port.sv
// Single-outstanding byte/half/word data memory port with fixed response latency
// and big-endian byte storage. Define DMEM_MISALIGN_TRAP_EN to reject misaligned accesses.
module data_memory_port #(
    parameter int  WORDS   = 256,
    parameter int  LATENCY = 2,
    localparam int ADDR_W  = $clog2(4*WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
    localparam int         WIDX_W   = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              accept;
    logic              enter_resp;

    logic              cap_write_reg;
    logic [1:0]        cap_size_reg;
    logic              cap_signed_reg;
    logic [ADDR_W-1:0] cap_addr_reg;
    logic [31:0]       cap_wdata_reg;

    function automatic logic is_err(input logic [1:0] size, input logic [1:0] off);
        is_err = (size == 2'b11) ||
                 (TRAP_EN && ((size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00)));
    endfunction

    // Byte offset within the word after alignment-down of half/word accesses.
    function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   align_off = {off[1], 1'b0};
            2'b10:   align_off = 2'b00;
            default: align_off = off;
        endcase
    endfunction

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            cap_write_reg  <= 1'b0;
            cap_size_reg   <= 2'b00;
            cap_signed_reg <= 1'b0;
            cap_addr_reg   <= '0;
            cap_wdata_reg  <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                cap_write_reg  <= req_write;
                cap_size_reg   <= req_size;
                cap_signed_reg <= req_signed;
                cap_addr_reg   <= req_addr;
                cap_wdata_reg  <= req_wdata;
            end
        end
    end

    // With LATENCY=1 the commit edge is the acceptance edge, so use the live request.
    logic              act_write;
    logic [1:0]        act_size;
    logic [ADDR_W-1:0] act_addr;
    logic [31:0]       act_wdata;
    logic              act_err;
    logic [1:0]        act_off;
    logic [WIDX_W-1:0] act_widx;

    always_comb begin
        if (state_reg == IDLE) begin
            act_write = req_write;
            act_size  = req_size;
            act_addr  = req_addr;
            act_wdata = req_wdata;
        end else begin
            act_write = cap_write_reg;
            act_size  = cap_size_reg;
            act_addr  = cap_addr_reg;
            act_wdata = cap_wdata_reg;
        end
        act_err  = is_err(act_size, act_addr[1:0]);
        act_off  = align_off(act_size, act_addr[1:0]);
        act_widx = act_addr[ADDR_W-1:2];
    end

    // Lane gi holds byte offset gi of each word, i.e. word bits [31-8*gi -: 8].
    logic [7:0] rd_byte [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [WORDS];
        logic [7:0] rd_q;
        logic       lane_en;
        logic [7:0] lane_wdata;

        always_comb begin
            case (act_size)
                2'b00: begin
                    lane_en    = (act_off == 2'(gi));
                    lane_wdata = act_wdata[7:0];
                end
                2'b01: begin
                    lane_en    = (act_off[1] == 1'(gi >> 1));
                    lane_wdata = (gi % 2 == 0) ? act_wdata[15:8] : act_wdata[7:0];
                end
                default: begin
                    lane_en    = 1'b1;
                    lane_wdata = act_wdata[31-8*gi -: 8];
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (enter_resp) begin
                if (act_write && !act_err && lane_en) mem[act_widx] <= lane_wdata;
                rd_q <= mem[act_widx];
            end
        end

        assign rd_byte[gi] = rd_q;
    end

    logic        cap_err;
    logic [1:0]  cap_off;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;

    always_comb begin
        cap_err  = is_err(cap_size_reg, cap_addr_reg[1:0]);
        cap_off  = align_off(cap_size_reg, cap_addr_reg[1:0]);
        byte_val = rd_byte[cap_off];
        half_val = {rd_byte[{cap_off[1], 1'b0}], rd_byte[{cap_off[1], 1'b1}]};
        case (cap_size_reg)
            2'b00:   load_val = cap_signed_reg ? {{24{byte_val[7]}}, byte_val} : {24'd0, byte_val};
            2'b01:   load_val = cap_signed_reg ? {{16{half_val[15]}}, half_val} : {16'd0, half_val};
            default: load_val = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
        endcase
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_err   = rsp_valid && cap_err;
    assign rsp_rdata = (rsp_valid && !cap_write_reg && !cap_err) ? load_val : 32'd0;

endmodule

// File: tb/tb_data_memory_port.sv
// Randomized bench for data_memory_port against a byte-array reference model;
// follows the DMEM_MISALIGN_TRAP_EN build setting.
module tb_data_memory_port;

    localparam int WORDS   = 256;
    localparam int LATENCY = 2;
    localparam int ADDR_W  = $clog2(4*WORDS);
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    int         n_vec = 0;
    int         n_bad = 0;
    int         n_txn = 0;
    logic [7:0] model_mem [WORDS*4];

    data_memory_port #(.WORDS(WORDS), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: n-byte big-endian access on a flat byte array.
    task automatic model_access(input logic w, input logic [1:0] sz, input logic sg,
                                input int addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
        int          a;
        int          n;
        logic [31:0] v;
        rd  = 32'd0;
        err = 1'b0;
        a   = addr;
        n   = 1 << sz;
        if (sz == 2'b11) begin
            err = 1'b1;
            return;
        end
        if (a % n != 0) begin
            if (TRAP) begin
                err = 1'b1;
                return;
            end
            a = a - (a % n);
        end
        if (w) begin
            for (int i = 0; i < n; i++) model_mem[a+i] = 8'(wd >> (8*(n-1-i)));
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = (v << 8) | {24'd0, model_mem[a+i]};
            if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rd = v;
        end
    endtask

    task automatic drive_junk();
        req_valid  = 1'($urandom);
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = ADDR_W'($urandom);
        req_wdata  = $urandom;
        rsp_ready  = 1'($urandom);
    endtask

    // Called while clk is low; returns just after a falling edge with the port idle.
    task automatic run_txn(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [ADDR_W-1:0] addr, input logic [31:0] wd, input int hold,
                           output logic [31:0] got_rd, output logic got_err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          cyc;
        model_access(w, sz, sg, int'(addr), wd, exp_rd, exp_err);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        rsp_ready  = 1'b0;
        @(posedge clk);
        #1;
        drive_junk();
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) break;
            drive_junk();
        end
        check("latency", 32'(cyc), 32'(LATENCY));
        got_rd  = rsp_rdata;
        got_err = rsp_err;
        check("rdata", rsp_rdata, exp_rd);
        check("err", {31'd0, rsp_err}, {31'd0, exp_err});
        for (int k = 0; k < hold; k++) begin
            drive_junk();
            rsp_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, exp_rd);
            check("hold_err", {31'd0, rsp_err}, {31'd0, exp_err});
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("release_valid", {31'd0, rsp_valid}, 32'd0);
        check("release_ready", {31'd0, req_ready}, 32'd1);
        n_txn++;
        $display("txn %0d: w=%0d sz=%0d sg=%0d addr=%h wd=%h hold=%0d -> rdata=%h err=%0d (exp %h/%0d)",
                 n_txn, w, sz, sg, addr, wd, hold, got_rd, got_err, exp_rd, exp_err);
    endtask

    initial begin : main
        logic [31:0]       rd;
        logic              er;
        logic [31:0]       prior;
        logic [1:0]        r_sz;
        logic [ADDR_W-1:0] r_addr;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b0;
        #3;
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Give the regions used below defined contents.
        for (int i = 0; i < 32; i++) run_txn(1'b1, 2'b10, 1'b0, ADDR_W'(4*i), $urandom, 0, rd, er);
        for (int i = 252; i < 256; i++) run_txn(1'b1, 2'b10, 1'b0, ADDR_W'(4*i), $urandom, 0, rd, er);

        run_txn(1'b1, 2'b10, 1'b0, ADDR_W'('h10), 32'h1122_3344, 0, rd, er);
        run_txn(1'b0, 2'b10, 1'b0, ADDR_W'('h10), 32'd0, 0, rd, er);
        check("word_roundtrip", rd, 32'h1122_3344);
        run_txn(1'b1, 2'b00, 1'b0, ADDR_W'('h12), 32'h0000_00AB, 0, rd, er);
        run_txn(1'b0, 2'b10, 1'b0, ADDR_W'('h10), 32'd0, 0, rd, er);
        check("byte_store_lane", rd, 32'h1122_AB44);
        run_txn(1'b0, 2'b00, 1'b1, ADDR_W'('h12), 32'd0, 0, rd, er);
        check("load_byte_signed", rd, 32'hFFFF_FFAB);
        run_txn(1'b0, 2'b00, 1'b0, ADDR_W'('h12), 32'd0, 0, rd, er);
        check("load_byte_unsigned", rd, 32'h0000_00AB);
        run_txn(1'b0, 2'b01, 1'b0, ADDR_W'('h11), 32'd0, 0, rd, er);
        check("misaligned_half_rdata", rd, TRAP ? 32'd0 : 32'h0000_1122);
        check("misaligned_half_err", {31'd0, er}, {31'd0, TRAP});
        run_txn(1'b0, 2'b10, 1'b0, ADDR_W'('h10), 32'd0, 5, rd, er);
        check("hold_load_word", rd, 32'h1122_AB44);

        // Store dropped by a reset pulse while waiting.
        prior = {model_mem['h20], model_mem['h21], model_mem['h22], model_mem['h23]};
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = ADDR_W'('h20);
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("wait_req_ready", {31'd0, req_ready}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_req_ready", {31'd0, req_ready}, 32'd1);
        check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midreset_rsp_rdata", rsp_rdata, 32'd0);
        check("midreset_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(posedge clk);
        #1;
        check("midreset_edge_ready", {31'd0, req_ready}, 32'd1);
        check("midreset_edge_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1'b0, 2'b10, 1'b0, ADDR_W'('h20), 32'd0, 0, rd, er);
        check("reset_dropped_store", rd, prior);

        run_txn(1'b1, 2'b11, 1'b0, ADDR_W'('h10), 32'hCAFE_F00D, 1, rd, er);
        check("reserved_size_err", {31'd0, er}, 32'd1);
        check("reserved_size_rdata", rd, 32'd0);
        run_txn(1'b0, 2'b10, 1'b0, ADDR_W'('h10), 32'd0, 0, rd, er);
        check("reserved_size_no_write", rd, 32'h1122_AB44);

        for (int t = 0; t < 200; t++) begin
            r_sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            r_addr = ($urandom_range(0, 7) == 0) ? ADDR_W'(1008 + $urandom_range(0, 15))
                                                 : ADDR_W'($urandom_range(0, 127));
            run_txn(1'($urandom), r_sz, 1'($urandom), r_addr, $urandom, $urandom_range(0, 3), rd, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
